ripple_carry_adder_unit: RTL and testbench

// - xlen-bit two-operand adder with carry-in; carry propagates bit by bit through a chain of 1-bit full adders.
// - Result and carry-out are registered once.
// - Datapath arithmetic primitive for the mini-cpu ALU.
// - Subtraction is done by the caller: drive b = ~operand and carry_in = 1.
//

---
 rtl/rca_pkg.sv | 29 ++
 rtl/full_adder.sv | 16 +
 rtl/ripple_carry_adder_unit.sv | 75 +++++++
 tb/tb_ripple_carry_adder_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants and a plain-arithmetic reference add for the ripple-carry adder.
// Optional signed-overflow output is enabled by defining RCA_OVERFLOW_EN.
package rca_pkg;

  localparam int unsigned RCA_XLEN_DEFAULT = 64;

  // Reference {cout, sum} for operand widths up to RCA_XLEN_DEFAULT; upper bits are masked.
  function automatic logic [RCA_XLEN_DEFAULT:0] rca_ref_add(
    input logic [RCA_XLEN_DEFAULT-1:0] a,
    input logic [RCA_XLEN_DEFAULT-1:0] b,
    input logic                        cin,
    input int unsigned                 width
  );
    logic [RCA_XLEN_DEFAULT-1:0] mask;
    logic [RCA_XLEN_DEFAULT:0]   full;
    logic [RCA_XLEN_DEFAULT:0]   res;
    if (width >= RCA_XLEN_DEFAULT) begin
      mask = '1;
    end else begin
      mask = (RCA_XLEN_DEFAULT'(1) << width) - RCA_XLEN_DEFAULT'(1);
    end
    full = {1'b0, a & mask} + {1'b0, b & mask} + {{RCA_XLEN_DEFAULT{1'b0}}, cin};
    res = '0;
    res[RCA_XLEN_DEFAULT-1:0] = full[RCA_XLEN_DEFAULT-1:0] & mask;
    res[RCA_XLEN_DEFAULT] = full[width];
    return res;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the cell chained by ripple_carry_adder_unit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_unit.sv
// xlen-bit ripple-carry adder with registered sum/carry; define RCA_OVERFLOW_EN to add
// a registered signed-overflow output.
module ripple_carry_adder_unit
  import rca_pkg::*;
#(
  parameter int unsigned xlen = RCA_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            carry_in,
  output logic            out_valid,
  output logic [xlen-1:0] sum,
  output logic            carry_out
`ifdef RCA_OVERFLOW_EN
  ,
  output logic            overflow
`endif
);

  logic [xlen:0]   c;
  logic [xlen-1:0] s;

  assign c[0] = carry_in;

  for (genvar i = 0; i < xlen; i++) begin : g_chain
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  logic            valid_q;
  logic [xlen-1:0] sum_q;
  logic            cout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      // Results hold while idle; only out_valid drops.
      if (in_valid) begin
        sum_q  <= s;
        cout_q <= c[xlen];
      end
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

`ifdef RCA_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= c[xlen] ^ c[xlen-1];
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_unit.sv
// Randomized bench for ripple_carry_adder_unit at xlen = 64, 8 and 1 against an arithmetic model.
module tb_ripple_carry_adder_unit;
  import rca_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        carry_in = 1'b0;

  logic        ov64, ov8, ov1;
  logic [63:0] sum64;
  logic [7:0]  sum8;
  logic        sum1;
  logic        co64, co8, co1;
`ifdef RCA_OVERFLOW_EN
  logic        of64, of8, of1;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ripple_carry_adder_unit #(.xlen(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .carry_in(carry_in),
    .out_valid(ov64), .sum(sum64), .carry_out(co64)
`ifdef RCA_OVERFLOW_EN
    , .overflow(of64)
`endif
  );

  ripple_carry_adder_unit #(.xlen(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[7:0]), .b(b[7:0]),
    .carry_in(carry_in), .out_valid(ov8), .sum(sum8), .carry_out(co8)
`ifdef RCA_OVERFLOW_EN
    , .overflow(of8)
`endif
  );

  ripple_carry_adder_unit #(.xlen(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .carry_in(carry_in), .out_valid(ov1), .sum(sum1), .carry_out(co1)
`ifdef RCA_OVERFLOW_EN
    , .overflow(of1)
`endif
  );

  int unsigned widths [3] = '{64, 8, 1};
  logic [63:0] o_sum [3];
  logic        o_cout [3];
  logic        o_valid [3];
  logic        o_ovf [3];

  assign o_sum[0]   = sum64;
  assign o_sum[1]   = {56'b0, sum8};
  assign o_sum[2]   = {63'b0, sum1};
  assign o_cout[0]  = co64;
  assign o_cout[1]  = co8;
  assign o_cout[2]  = co1;
  assign o_valid[0] = ov64;
  assign o_valid[1] = ov8;
  assign o_valid[2] = ov1;
`ifdef RCA_OVERFLOW_EN
  assign o_ovf[0] = of64;
  assign o_ovf[1] = of8;
  assign o_ovf[2] = of1;
`else
  assign o_ovf[0] = 1'b0;
  assign o_ovf[1] = 1'b0;
  assign o_ovf[2] = 1'b0;
`endif

  // Expected register contents, one entry per width.
  logic [63:0] m_sum [3];
  logic        m_cout [3];
  logic        m_valid [3];
  logic        m_ovf [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w%0d_valid", widths[k]), 64'(o_valid[k]), 64'(m_valid[k]));
      check($sformatf("w%0d_sum", widths[k]), o_sum[k], m_sum[k]);
      check($sformatf("w%0d_cout", widths[k]), 64'(o_cout[k]), 64'(m_cout[k]));
`ifdef RCA_OVERFLOW_EN
      check($sformatf("w%0d_ovf", widths[k]), 64'(o_ovf[k]), 64'(m_ovf[k]));
`endif
    end
  endtask

  // Apply one cycle of stimulus, advance the model and compare all widths.
  task automatic step(input logic r, input logic v, input logic [63:0] ai,
                      input logic [63:0] bi, input logic ci);
    logic [64:0]  ref_res;
    int unsigned  w;
    @(negedge clk);
    rst_n = r;
    in_valid = v;
    a = ai;
    b = bi;
    carry_in = ci;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      w = widths[k];
      if (!r) begin
        m_sum[k] = '0;
        m_cout[k] = 1'b0;
        m_valid[k] = 1'b0;
        m_ovf[k] = 1'b0;
      end else begin
        m_valid[k] = v;
        if (v) begin
          ref_res = rca_ref_add(ai, bi, ci, w);
          m_sum[k] = ref_res[63:0];
          m_cout[k] = ref_res[64];
          // Signed overflow: like-signed operands giving a result of the other sign.
          m_ovf[k] = (ai[w-1] == bi[w-1]) && (ref_res[w-1] != ai[w-1]);
        end
      end
    end
    compare_all();
  endtask

  initial begin
    logic [63:0] ra, rb;
    for (int k = 0; k < 3; k++) begin
      m_sum[k] = '0;
      m_cout[k] = 1'b0;
      m_valid[k] = 1'b0;
      m_ovf[k] = 1'b0;
    end

    // Reset with random operands present.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    end
    check("rst_sum64", sum64, 64'd0);
    check("rst_valid64", 64'(ov64), 64'd0);

    step(1'b1, 1'b1, 64'd0, 64'd0, 1'b0);
    check("zero_sum64", sum64, 64'd0);
    check("zero_valid64", 64'(ov64), 64'd1);

    step(1'b1, 1'b1, '1, 64'd1, 1'b0);
    check("wrap_sum64", sum64, 64'd0);
    check("wrap_cout64", 64'(co64), 64'd1);
`ifdef RCA_OVERFLOW_EN
    check("wrap_ovf64", 64'(of64), 64'd0);
`endif

    step(1'b1, 1'b1, 64'd53, ~64'd48, 1'b1);
    check("sub_sum64", sum64, 64'd5);
    check("sub_cout64", 64'(co64), 64'd1);

    step(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("smax_sum64", sum64, 64'h8000_0000_0000_0000);
    check("smax_cout64", 64'(co64), 64'd0);
`ifdef RCA_OVERFLOW_EN
    check("smax_ovf64", 64'(of64), 64'd1);
`endif

    // Idle cycle: result holds, valid drops.
    step(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    check("idle_sum64", sum64, 64'h8000_0000_0000_0000);
    check("idle_valid64", 64'(ov64), 64'd0);

    // Mid-stream reset clears outputs.
    step(1'b1, 1'b1, '1, '1, 1'b1);
    step(1'b0, 1'b1, 64'd3, 64'd4, 1'b0);
    check("midrst_sum64", sum64, 64'd0);
    check("midrst_cout64", 64'(co64), 64'd0);

    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      // Bias some operands toward carry-heavy patterns.
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      step(($urandom_range(0, 49) != 0), 1'($urandom), ra, rb, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
